// File: rtl/isp_ahb_pkg.sv
// Shared AHB-Lite constants, cfg-master state encoding and ISP register map.
// Used by the ISP configuration master and, for the register offsets, by the ISP slave.
package isp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_RB_ADDR = 3'd3,
    ST_RB_DATA = 3'd4,
    ST_RESP    = 3'd5
  } cfg_state_e;

  localparam logic [11:0] REG_CTRL = 12'h000;
  localparam logic [11:0] REG_SIZE = 12'h004;
  localparam logic [11:0] REG_GAIN = 12'h008;
  localparam logic [11:0] REG_MODE = 12'h00C;

endpackage

// File: rtl/isp_ahb_cfg_master.sv
// AHB-Lite single-transfer master turning a command handshake into ISP register accesses.
// Define ISP_CFG_READBACK_EN to verify every successful write with a readback read.
module isp_ahb_cfg_master
  import isp_ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          OFS_W     = 12
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [OFS_W-1:0] cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  cfg_state_e  state_reg;
  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= ST_IDLE;
      write_reg <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            write_reg <= cmd_write;
            addr_reg  <= BASE_ADDR + {{(32-OFS_W){1'b0}}, cmd_addr};
            wdata_reg <= cmd_wdata;
            // Misaligned offsets never reach the bus; report no data with the error.
            if (cmd_addr[1:0] != 2'b00) begin
              rdata_reg <= 32'h0;
              err_reg   <= 1'b1;
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (HREADY) begin
            rdata_reg <= HRDATA;
            err_reg   <= HRESP;
`ifdef ISP_CFG_READBACK_EN
            if (write_reg && !HRESP) state_reg <= ST_RB_ADDR;
            else                     state_reg <= ST_RESP;
`else
            state_reg <= ST_RESP;
`endif
          end
        end
`ifdef ISP_CFG_READBACK_EN
        ST_RB_ADDR: begin
          if (HREADY) state_reg <= ST_RB_DATA;
        end
        ST_RB_DATA: begin
          if (HREADY) begin
            rdata_reg <= HRDATA;
            err_reg   <= HRESP | (HRDATA != wdata_reg);
            state_reg <= ST_RESP;
          end
        end
`endif
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bus controls decode straight from state so an async reset clears them at once.
  assign HTRANS    = (state_reg == ST_ADDR || state_reg == ST_RB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = (state_reg == ST_ADDR) ? write_reg : 1'b0;
  assign HADDR     = addr_reg;
  assign HWDATA    = wdata_reg;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_isp_ahb_cfg_master.sv
// Directed bench for isp_ahb_cfg_master; the bench acts as the ISP slave.
// Expectations follow ISP_CFG_READBACK_EN when it is defined for the build.
module tb_isp_ahb_cfg_master;
  import isp_ahb_pkg::*;

  localparam logic [31:0] TB_BASE = 32'h4001_0000;
`ifdef ISP_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  isp_ahb_cfg_master #(.BASE_ADDR(TB_BASE), .OFS_W(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One command end to end. waits = wait states in the first data phase; err = two-cycle
  // ERROR ending that phase (needs waits>=1). rd / rb = HRDATA for first / readback phase.
  task automatic run_cmd(input string tag, input bit wr, input logic [11:0] ofs,
                         input logic [31:0] wd, input int waits, input bit err,
                         input logic [31:0] rd, input logic [31:0] rb,
                         input int exp_cycle, input bit exp_err, input logic [31:0] exp_rdata,
                         input int exp_nonseq, input int exp_hold);
    int cyc = 0;
    int nonseq = 0;
    int phase = 0;
    int dcyc = 0;
    int hold = 0;
    bit in_data = 1'b0;
    bit done = 1'b0;
    @(negedge HCLK);
    check_value({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = ofs; cmd_wdata = wd;
    while (!done && cyc < 40) begin
      @(negedge HCLK);
      cyc++;
      cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
      if (cyc == 1) check_value({tag, " busy"}, 32'(busy), 32'd1);
      if (rsp_valid) begin
        done = 1'b1;
        check_value({tag, " rsp_cycle"}, 32'(cyc), 32'(exp_cycle));
        check_value({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check_value({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
      end else if (HTRANS == HTRANS_NONSEQ) begin
        nonseq++;
        phase++;
        dcyc = 0;
        in_data = 1'b1;
        check_value({tag, " haddr"}, HADDR, TB_BASE + {20'h0, ofs});
        check_value({tag, " hwrite"}, 32'(HWRITE), (phase == 1) ? 32'(wr) : 32'd0);
      end else if (in_data) begin
        dcyc++;
        if (phase == 1 && wr && HWDATA == wd) hold++;
        if (phase == 1 && dcyc <= waits) begin
          HREADY = 1'b0;
          HRESP  = err && (dcyc == waits);
        end else begin
          HRDATA  = (phase == 1) ? rd : rb;
          HRESP   = (phase == 1) && err;
          in_data = 1'b0;
        end
      end
    end
    if (!done) check_value({tag, " timeout_cycle"}, 32'(cyc), 32'(exp_cycle));
    check_value({tag, " nonseq_count"}, 32'(nonseq), 32'(exp_nonseq));
    check_value({tag, " hwdata_hold"}, 32'(hold), 32'(exp_hold));
    @(negedge HCLK);
    check_value({tag, " busy_after"}, 32'(busy), 32'd0);
    check_value({tag, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    $display("cmd %s wr=%0d ofs=%h wd=%h -> cycle=%0d err=%0d rdata=%h nonseq=%0d",
             tag, wr, ofs, wd, cyc, rsp_err, rsp_rdata, nonseq);
  endtask

  // Zero-wait write of a register; the bench's rd value differs from wd on purpose.
  task automatic write0(input string tag, input logic [11:0] ofs, input logic [31:0] wd,
                        input logic [31:0] rd);
    run_cmd(tag, 1'b1, ofs, wd, 0, 1'b0, rd, wd, RB ? 5 : 3, 1'b0, RB ? wd : rd,
            RB ? 2 : 1, 1);
  endtask

  initial begin
    int rsp_seen;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    #1;
    check_value("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check_value("rst busy", 32'(busy), 32'd0);
    check_value("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_value("rst rsp_rdata", rsp_rdata, 32'h0);
    check_value("rst rsp_err", 32'(rsp_err), 32'd0);
    check_value("rst htrans", 32'(HTRANS), 32'd0);
    check_value("rst haddr", HADDR, 32'h0);
    check_value("rst hwrite", 32'(HWRITE), 32'd0);
    check_value("rst hwdata", HWDATA, 32'h0);
    check_value("hsize", 32'(HSIZE), 32'd2);
    check_value("hburst", 32'(HBURST), 32'd0);
    check_value("hprot", 32'(HPROT), 32'd3);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    write0("wr_ctrl", REG_CTRL, 32'h0000_0004, 32'h5555_0001);
    write0("wr_size", REG_SIZE, 32'h1001_5010, 32'h5555_0002);
    write0("wr_gain", REG_GAIN, 32'h8899_AA00, 32'h5555_0003);
    write0("wr_mode", REG_MODE, 32'h0000_0002, 32'h5555_0004);

    run_cmd("wr_wait3", 1'b1, REG_SIZE, 32'h1001_5010, 3, 1'b0, 32'h0BAD_F00D, 32'h1001_5010,
            RB ? 8 : 6, 1'b0, RB ? 32'h1001_5010 : 32'h0BAD_F00D, RB ? 2 : 1, 4);
    run_cmd("wr_error", 1'b1, REG_GAIN, 32'h8899_AA00, 1, 1'b1, 32'h0000_00EE, 32'h8899_AA00,
            4, 1'b1, 32'h0000_00EE, 1, 2);
    run_cmd("misaligned", 1'b1, 12'h006, 32'hCAFE_0001, 0, 1'b0, 32'h0, 32'h0,
            1, 1'b1, 32'h0, 0, 0);
    run_cmd("rd_mode", 1'b0, REG_MODE, 32'h0, 0, 1'b0, 32'h1234_5678, 32'h0,
            3, 1'b0, 32'h1234_5678, 1, 0);
    run_cmd("rd_after_err", 1'b0, REG_CTRL, 32'h0, 2, 1'b0, 32'h0000_0004, 32'h0,
            5, 1'b0, 32'h0000_0004, 1, 0);
`ifdef ISP_CFG_READBACK_EN
    run_cmd("rb_mismatch", 1'b1, REG_GAIN, 32'h8899_AA00, 0, 1'b0, 32'h0, 32'h8899_AA0F,
            5, 1'b1, 32'h8899_AA0F, 2, 1);
`endif

    // Reset pulsed during the data phase of a write.
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_SIZE; cmd_wdata = 32'h7777_0000;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check_value("rstmid nonseq", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    check_value("rstmid htrans", 32'(HTRANS), 32'd0);
    check_value("rstmid cmd_ready", 32'(cmd_ready), 32'd1);
    check_value("rstmid busy", 32'(busy), 32'd0);
    check_value("rstmid haddr", HADDR, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      if (rsp_valid) rsp_seen++;
    end
    check_value("rstmid no_rsp", 32'(rsp_seen), 32'd0);
    $display("cmd rstmid aborted write, rsp pulses after reset=%0d", rsp_seen);
    write0("wr_post_rst", REG_CTRL, 32'h0000_0001, 32'h5555_0005);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/isp_ahb_cfg_master.md
# isp_ahb_cfg_master

AHB-Lite single-transfer master that turns a simple command handshake into 32-bit register writes and reads on the ISP configuration slave's bus. It sits between a control source (boot sequencer, debug port, or a CPU-side bridge) and the ISP's AHB slave port, so the ISP can be programmed without a processor. Each command produces exactly one AHB transfer, plus one optional readback-verify read, and one response pulse.

## Interface
- BASE_ADDR, 32'h0000_0000, added to every command offset to form HADDR
- OFS_W, 12, width of the command address offset
- HCLK  in  1  system clock; all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  OFS_W  byte offset; bits [1:0] must be 0
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data (reads, readback value)
- rsp_err  out  1  slave ERROR, misaligned offset, or readback mismatch
- busy  out  1  high from acceptance through the rsp_valid cycle
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3, HPROT  out  4, HWDATA  out  32
- HRDATA  in  32, HREADY  in  1, HRESP  in  1

## Operation
- States: IDLE, ADDR, DATA, RB_ADDR, RB_DATA, RESP.
- IDLE: cmd_ready=1. On acceptance, latch write, offset and wdata.
  - Offset [1:0]≠0: go to RESP with rsp_err=1 and no bus transfer.
  - Otherwise go to ADDR.
- ADDR: HTRANS=NONSEQ, HADDR=BASE_ADDR+offset (32-bit wrap, no carry flag), HWRITE=latched write. Stay while HREADY=0. On HREADY=1 go to DATA.
- DATA: HTRANS=IDLE, HWDATA=latched wdata, held stable until HREADY=1. On HREADY=1 capture HRDATA and HRESP.
  - Write, no error, readback enabled: go to RB_ADDR.
  - All other cases: go to RESP.
- RB_ADDR / RB_DATA: same as ADDR/DATA with HWRITE=0 at the same address. Captured HRDATA is compared with the latched wdata.
- RESP: rsp_valid=1 for one cycle, then IDLE. rsp_rdata and rsp_err hold their values until the next RESP.
- rsp_err = HRESP from any completed data phase, OR misaligned offset, OR readback mismatch. On mismatch, rsp_rdata = readback value.
- A write that returns ERROR skips readback.
- HRESP=1 with HREADY=0 (first cycle of a two-cycle ERROR response): the master is already at HTRANS=IDLE and simply waits.
- Constant outputs: HSIZE=3'b010, HBURST=3'b000 (SINGLE), HPROT=4'b0011.
- Never issues back-to-back or pipelined transfers; HTRANS is NONSEQ only in ADDR/RB_ADDR.

## Timing
- Reset values: state=IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously); no response is issued for the aborted command.
- Zero wait states, accept at cycle 0: ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3.
- Readback adds 2 cycles, so rsp_valid lands in cycle 5.
- Each wait state (HREADY=0) in any phase adds exactly 1 cycle.
- Misaligned command: rsp_valid in cycle 1.
- Maximum command throughput: one command per 4 cycles (6 with readback).
- cmd_valid asserted while busy: the command is ignored and must be held by the source until cmd_ready.

## Configuration
- ISP_CFG_READBACK_EN defined: RB_ADDR/RB_DATA are compiled in and every successful write is verified.
- ISP_CFG_READBACK_EN undefined: those states are absent, a write goes DATA→RESP, and rsp_rdata on writes is HRDATA as sampled in DATA.

## Structure
- Shared package isp_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, HPROT_DATA constants
  - the cfg-master state enum type
  - register offsets REG_CTRL=0x0, REG_SIZE=0x4, REG_GAIN=0x8, REG_MODE=0xC, shared with the ISP slave
- No sub-module: a single FSM plus latches. The ISP slave is the bench's response model.

## Test plan
- Zero-wait writes of 0x0←0x0000_0004, 0x4←0x1001_5010, 0x8←0x8899_AA00, 0xC←0x0000_0002 → HADDR 0x0/0x4/0x8/0xC with NONSEQ one cycle each; HWDATA matches in the following cycle; rsp_valid at cycle 3 (5 with readback); rsp_err=0.
- Write 0x4 with 3 wait states inserted in the data phase → HWDATA held for 4 cycles; rsp_valid at cycle 6; exactly one NONSEQ.
- Slave returns a two-cycle ERROR on a write to 0x8 → rsp_err=1; no readback transfer; busy drops after RESP.
- cmd_addr=0x6 → rsp_valid at cycle 1 with rsp_err=1; HTRANS stays IDLE throughout.
- With ISP_CFG_READBACK_EN, slave masks the write to 0x8 and reads back 0x8899_AA0F → rsp_err=1, rsp_rdata=0x8899_AA0F.
- HRESET pulsed during DATA of a write → HTRANS=IDLE and cmd_ready=1 immediately; no rsp_valid; the next command completes normally.
